// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a producer and a uart_tx; head word is registered, so a write to an empty FIFO is visible the next cycle.
// Full/empty, count and overflow come from registers; overflow flags a producer valid that met a full FIFO.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  flush,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic                  wr_en, rd_en;

   assign wr_en      = s_axis_tvalid & s_axis_tready & ~flush;
   assign rd_en      = m_axis_tvalid & m_axis_tready & ~flush;
   assign rd_ptr_nxt = rd_ptr + PTR_ONE;

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = CNT_ZERO;
      else if (wr_en && !rd_en)
         count_nxt = count + CNT_ONE;
      else if (rd_en && !wr_en)
         count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= s_axis_tdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         s_axis_tready <= 1'b0;
         m_axis_tvalid <= 1'b0;
         overflow      <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         overflow      <= s_axis_tvalid & ~s_axis_tready & ~flush;
         count         <= count_nxt;
         s_axis_tready <= (count_nxt != FULL_CNT);
         m_axis_tvalid <= (count_nxt != CNT_ZERO);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en)
               wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)
               rd_ptr <= rd_ptr_nxt;
            // Incoming word bypasses storage when it becomes the new head.
            if (wr_en && (count == CNT_ZERO || (count == CNT_ONE && rd_en)))
               m_axis_tdata <= s_axis_tdata;
            else if (rd_en && count > CNT_ONE)
               m_axis_tdata <= mem[rd_ptr_nxt];
         end
      end
   end
endmodule
